pid_cfg_writer: RTL and testbench

//  Initiator side of the pid register-write port. Drives write_enable (active-low), reg_addr and reg_data.

---
 rtl/pid_cfg_writer.sv | 210 +++++++++++++++++++++
 tb/tb_pid_cfg_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_cfg_writer.sv
// rtl/pid_cfg_writer.sv - batch-atomic gain writer feeding the pid register port
// Purpose: buffers host gain writes in a FIFO and replays them to pid one per cycle,
//          holding iterate_enable low from the first write of a batch until one
//          settle cycle after its commit write, so pid never runs on a half-updated
//          gain set. Optional feature macro: PID_CFG_AUTOLOAD_EN (after reset, load
//          KP_INIT/KI_INIT/KD_INIT into regs 0..NUM_REGS-1 before the first RUN).
// Ports:
//   clk, rstb                     clock (rising edge), asynchronous active-low reset
//   host_valid/host_ready         host write handshake, beat moves on valid & ready
//   host_addr/host_data           target register and Q13 value
//   host_commit                   last beat of a batch
//   write_enable                  active-low register write strobe to pid
//   reg_addr/reg_data             zero-extended register address and value to pid
//   iterate_enable                pid loop run enable
//   busy                          high whenever the FSM is not in RUN
//   err_pulse                     one-cycle pulse: illegal address dropped or forced flush
module pid_cfg_writer #(
   parameter int                 D_WIDTH    = 16,
   parameter int                 ADDR_W     = 2,
   parameter int                 NUM_REGS   = 3,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [D_WIDTH-1:0] KP_INIT    = 16'h0200,
   parameter logic [D_WIDTH-1:0] KI_INIT    = 16'h1000,
   parameter logic [D_WIDTH-1:0] KD_INIT    = 16'h0000
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic [ADDR_W-1:0]  host_addr,
   input  logic [D_WIDTH-1:0] host_data,
   input  logic               host_commit,
   output logic               write_enable,
   output logic [D_WIDTH-1:0] reg_addr,
   output logic [D_WIDTH-1:0] reg_data,
   output logic               iterate_enable,
   output logic               busy,
   output logic               err_pulse
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + ADDR_W + D_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(NUM_REGS + 1);

   typedef enum logic [2:0] {BOOT, IDLE, WRITE, SETTLE, RUN} state_t;

`ifdef PID_CFG_AUTOLOAD_EN
   localparam state_t RESET_STATE = BOOT;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   function automatic logic [D_WIDTH-1:0] init_val(input logic [BW-1:0] idx);
      if (int'(idx) == 0)      return KP_INIT;
      else if (int'(idx) == 1) return KI_INIT;
      else if (int'(idx) == 2) return KD_INIT;
      else                     return '0;
   endfunction

   state_t             state, state_nxt;
   logic [EW-1:0]      mem [FIFO_DEPTH];
   logic [PW:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0]      commit_cnt;
   logic [BW-1:0]      boot_idx, boot_idx_nxt;
   logic               flushing, flushing_nxt, last_commit, last_commit_nxt;
   logic               empty, full, full_nxt, accept, legal, push, pop, drop_err, force_err;
   logic [EW-1:0]      push_entry, head;
   logic               head_commit, head_legal;
   logic [ADDR_W-1:0]  head_addr;
   logic               we_nxt, iter_nxt;
   logic [D_WIDTH-1:0] addr_nxt, data_nxt;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   // An illegal beat carrying commit becomes a data-less marker: it keeps its
   // out-of-range address so the pop side knows not to strobe, but still ends the batch.
   assign accept     = host_valid && host_ready;
   assign legal      = int'(host_addr) < NUM_REGS;
   assign push       = accept && (legal || host_commit);
   assign drop_err   = accept && !legal;
   assign push_entry = legal ? {host_commit, host_addr, host_data}
                             : {1'b1, host_addr, {D_WIDTH{1'b0}}};

   assign head        = mem[rd_ptr[PW-1:0]];
   assign head_commit = head[EW-1];
   assign head_addr   = head[D_WIDTH +: ADDR_W];
   assign head_legal  = int'(head_addr) < NUM_REGS;

   assign wr_ptr_nxt = wr_ptr + (PW+1)'(push);
   assign rd_ptr_nxt = rd_ptr + (PW+1)'(pop);
   assign full_nxt   = (wr_ptr_nxt[PW] != rd_ptr_nxt[PW]) &&
                       (wr_ptr_nxt[PW-1:0] == rd_ptr_nxt[PW-1:0]);

   always_comb begin
      state_nxt       = state;
      boot_idx_nxt    = boot_idx;
      flushing_nxt    = flushing;
      last_commit_nxt = 1'b0;
      pop             = 1'b0;
      force_err       = 1'b0;
      we_nxt          = 1'b1;
      addr_nxt        = reg_addr;
      data_nxt        = reg_data;
      iter_nxt        = 1'b0;
      case (state)
         BOOT: begin
            if (int'(boot_idx) < NUM_REGS) begin
               we_nxt       = 1'b0;
               addr_nxt     = D_WIDTH'(boot_idx);
               data_nxt     = init_val(boot_idx);
               boot_idx_nxt = boot_idx + BW'(1);
            end else begin
               state_nxt = SETTLE;
            end
         end
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            // The commit entry's write is on the bus now; settle before running.
            if (last_commit) begin
               state_nxt    = SETTLE;
               flushing_nxt = 1'b0;
            end else if (!empty) begin
               pop = 1'b1;
            end else if (flushing) begin
               state_nxt    = SETTLE;
               flushing_nxt = 1'b0;
            end else begin
               state_nxt = IDLE;
            end
         end
         SETTLE: begin
            state_nxt = RUN;
            iter_nxt  = 1'b1;
         end
         RUN: begin
            if (commit_cnt != '0) begin
               pop       = 1'b1;
               state_nxt = WRITE;
            end else if (full) begin
               // Nothing committed yet the host can no longer make progress: drain anyway.
               pop          = 1'b1;
               state_nxt    = WRITE;
               flushing_nxt = 1'b1;
               force_err    = 1'b1;
            end else begin
               iter_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (pop) begin
         last_commit_nxt = head_commit;
         if (head_legal) begin
            we_nxt   = 1'b0;
            addr_nxt = D_WIDTH'(head_addr);
            data_nxt = head[D_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= push_entry;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state          <= RESET_STATE;
         boot_idx       <= '0;
         flushing       <= 1'b0;
         last_commit    <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         commit_cnt     <= '0;
         write_enable   <= 1'b1;
         reg_addr       <= '0;
         reg_data       <= '0;
         iterate_enable <= 1'b0;
         host_ready     <= 1'b0;
         busy           <= 1'b1;
         err_pulse      <= 1'b0;
      end else begin
         state          <= state_nxt;
         boot_idx       <= boot_idx_nxt;
         flushing       <= flushing_nxt;
         last_commit    <= last_commit_nxt;
         wr_ptr         <= wr_ptr_nxt;
         rd_ptr         <= rd_ptr_nxt;
         case ({push && push_entry[EW-1], pop && head_commit})
            2'b10:   commit_cnt <= commit_cnt + CW'(1);
            2'b01:   commit_cnt <= commit_cnt - CW'(1);
            default: commit_cnt <= commit_cnt;
         endcase
         write_enable   <= we_nxt;
         reg_addr       <= addr_nxt;
         reg_data       <= data_nxt;
         iterate_enable <= iter_nxt;
         host_ready     <= !full_nxt;
         busy           <= (state_nxt != RUN);
         err_pulse      <= drop_err || force_err;
      end
   end

endmodule

// File: tb/tb_pid_cfg_writer.sv
// tb/tb_pid_cfg_writer.sv - self-checking bench for pid_cfg_writer
module tb_pid_cfg_writer;

   logic        clk = 1'b0;
   logic        rstb = 1'b1;
   logic        host_valid = 1'b0;
   logic        host_commit = 1'b0;
   logic [1:0]  host_addr = '0;
   logic [15:0] host_data = '0;
   logic        host_ready, write_enable, iterate_enable, busy, err_pulse;
   logic [15:0] reg_addr, reg_data;

   int vectors = 0;
   int miscompares = 0;
   int err_seen = 0;
   int conflicts = 0;
   int err_base;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   logic [15:0] model_g [3] = '{16'h0200, 16'h1000, 16'h0000};
   logic [15:0] shadow_g[3] = '{16'h0200, 16'h1000, 16'h0000};

   always #5 clk = ~clk;

   pid_cfg_writer dut (
      .clk(clk), .rstb(rstb), .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_data(host_data), .host_commit(host_commit),
      .write_enable(write_enable), .reg_addr(reg_addr), .reg_data(reg_data),
      .iterate_enable(iterate_enable), .busy(busy), .err_pulse(err_pulse)
   );

   always @(negedge clk) begin
      if (rstb) begin
         if (write_enable === 1'b0) obs_q.push_back({reg_addr, reg_data});
         if (err_pulse === 1'b1) err_seen++;
         if (iterate_enable === 1'b1 && write_enable !== 1'b1) conflicts++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] a, input logic [15:0] d, input logic c, output bit ok);
      bool_loop: begin end
      host_valid = 1'b1; host_addr = a; host_data = d; host_commit = c;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (host_ready === 1'b1) ok = 1'b1;
         step();
      end
      host_valid = 1'b0; host_commit = 1'b0;
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         if (busy === 1'b0 && iterate_enable === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic clear_obs();
      obs_q.delete();
      exp_q.delete();
      err_base = err_seen;
   endtask

   task automatic check_writes(input string tag);
      logic [31:0] o, e;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_write"}, o, e);
         if (o[31:16] < 32'd3) shadow_g[o[17:16]] = o[15:0];
      end
   endtask

   initial begin
      bit ok;
      int zeros;
      int len, has_bad, bad_pos;
      logic [1:0]  a;
      logic [15:0] d;

      #1 rstb = 1'b0;
      repeat (3) step();
      chk("rst_we", write_enable, 1);
      chk("rst_addr", reg_addr, 0);
      chk("rst_data", reg_data, 0);
      chk("rst_iter", iterate_enable, 0);
      chk("rst_ready", host_ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_err", err_pulse, 0);
      rstb = 1'b1;

`ifdef PID_CFG_AUTOLOAD_EN
      step();
      chk("boot0", {write_enable, reg_addr, reg_data}, {1'b0, 16'd0, 16'h0200});
      chk("boot_ready", host_ready, 1);
      step();
      chk("boot1", {write_enable, reg_addr, reg_data}, {1'b0, 16'd1, 16'h1000});
      step();
      chk("boot2", {write_enable, reg_addr, reg_data}, {1'b0, 16'd2, 16'h0000});
      step();
      chk("boot_settle", {write_enable, iterate_enable, busy}, 3'b101);
      step();
      chk("boot_run", {iterate_enable, busy}, 2'b10);
`else
      step();
      chk("idle_ready", host_ready, 1);
      repeat (3) step();
      chk("idle_state", {write_enable, iterate_enable, busy}, 3'b101);
      push(2'd2, 16'h0010, 1'b1, ok);
      chk("first_accept", ok, 1);
      chk("first_pre", write_enable, 1);
      step();
      chk("first_write", {write_enable, reg_addr, reg_data, iterate_enable}, {1'b0, 16'd2, 16'h0010, 1'b0});
      step();
      chk("first_settle", {write_enable, iterate_enable, busy}, 3'b101);
      step();
      chk("first_run", {iterate_enable, busy}, 2'b10);
      model_g[2] = 16'h0010;
      shadow_g[2] = 16'h0010;
`endif

      // Two-beat committed batch from RUN.
      clear_obs();
      push(2'd0, 16'h0400, 1'b0, ok);
      chk("b2_accept0", ok, 1);
      chk("b2_still_run", {iterate_enable, busy, write_enable}, 3'b101);
      push(2'd1, 16'h0800, 1'b1, ok);
      chk("b2_accept1", ok, 1);
      zeros = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (iterate_enable === 1'b0) zeros++;
      end
      chk("b2_iter_gap", zeros, 3);
      exp_q.push_back({16'd0, 16'h0400});
      exp_q.push_back({16'd1, 16'h0800});
      model_g[0] = 16'h0400; model_g[1] = 16'h0800;
      check_writes("b2");
      chk("b2_iter_back", iterate_enable, 1);

      // Illegal address is dropped with a single error pulse.
      clear_obs();
      push(2'd3, 16'h1234, 1'b0, ok);
      chk("bad_accept", ok, 1);
      chk("bad_err", err_pulse, 1);
      step();
      chk("bad_err_end", err_pulse, 0);
      repeat (4) step();
      check_writes("bad");
      chk("bad_err_cnt", err_seen - err_base, 1);
      chk("bad_iter", iterate_enable, 1);

      // Four uncommitted beats fill the FIFO and force a flush.
      clear_obs();
      for (int i = 0; i < 4; i++) begin
         a = 2'(i % 3);
         d = 16'($urandom);
         push(a, d, 1'b0, ok);
         chk("fl_accept", ok, 1);
         chk("fl_ready", host_ready, (i < 3) ? 1 : 0);
         exp_q.push_back({14'd0, a, d});
         model_g[a] = d;
      end
      chk("fl_iter_pre", iterate_enable, 1);
      step();
      chk("fl_first", {write_enable, err_pulse, iterate_enable}, 3'b010);
      wait_run(ok);
      chk("fl_back_run", ok, 1);
      check_writes("fl");
      chk("fl_err_cnt", err_seen - err_base, 1);

      // Randomised committed batches, optionally with a dropped illegal beat.
      for (int b = 0; b < 12; b++) begin
         clear_obs();
         len = int'($urandom_range(1, 4));
         has_bad = int'($urandom_range(0, 1));
         bad_pos = int'($urandom_range(0, len - 1));
         for (int i = 0; i < len; i++) begin
            if (has_bad != 0 && i == bad_pos) begin
               push(2'd3, 16'($urandom), 1'b0, ok);
               chk("rnd_bad_accept", ok, 1);
            end
            a = 2'($urandom_range(0, 2));
            d = 16'($urandom);
            push(a, d, (i == len - 1), ok);
            chk("rnd_accept", ok, 1);
            exp_q.push_back({14'd0, a, d});
            model_g[a] = d;
         end
         repeat (2) step();
         wait_run(ok);
         chk("rnd_run", ok, 1);
         check_writes("rnd");
         chk("rnd_err_cnt", err_seen - err_base, has_bad);
         for (int r = 0; r < 3; r++) chk("rnd_gain", shadow_g[r], model_g[r]);
      end

      // Reset in the middle of a three-write batch.
      clear_obs();
      push(2'd0, 16'h1111, 1'b0, ok);
      push(2'd1, 16'h2222, 1'b0, ok);
      push(2'd2, 16'h3333, 1'b1, ok);
      chk("mid_accept", ok, 1);
      step();
      chk("mid_w1", {write_enable, reg_data}, {1'b0, 16'h1111});
      step();
      chk("mid_w2", {write_enable, reg_data}, {1'b0, 16'h2222});
      #2 rstb = 1'b0;
      #1;
      chk("mid_rst_outs", {write_enable, iterate_enable, busy, host_ready}, 4'b1010);
      step();
      rstb = 1'b1;
      obs_q.delete();
      exp_q.delete();
`ifdef PID_CFG_AUTOLOAD_EN
      exp_q.push_back({16'd0, 16'h0200});
      exp_q.push_back({16'd1, 16'h1000});
      exp_q.push_back({16'd2, 16'h0000});
      wait_run(ok);
      chk("mid_reboot", ok, 1);
      repeat (3) step();
`else
      repeat (6) step();
      chk("mid_idle", {write_enable, iterate_enable, busy, host_ready}, 4'b1011);
`endif
      check_writes("mid");

      chk("no_iter_during_write", conflicts, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
